brush_painter: RTL and testbench
================================

Name: brush_painter

Overview:
- Upstream stage of the pixel store: converts cursor/brush commands into a stream of single-pixel writes on the store's write port (brush, newColor, wx, wy).
- Each accepted command paints a square brush footprint around a centre point, or clears the whole 128x128 canvas.
- Emits one write per clock. Pixels that fall off the canvas are clipped.
- Commands arrive over a valid/ready handshake from the input decoder.

Parameters:
- CANVAS, 128, canvas side in pixels; coordinates are 0..CANVAS-1. Must be a power of 2, at most 128.
- MAX_RADIUS, 3, largest brush radius accepted; cmd_size is saturated to this value.
- ERASE_COLOR, 3'b000, colour code written during a clear.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_clear  in  1  1 = clear canvas; cmd_x, cmd_y, cmd_size, cmd_color are ignored
- cmd_x  in  7  brush centre x
- cmd_y  in  7  brush centre y
- cmd_size  in  2  brush radius r; footprint side is 2r+1
- cmd_color  in  3  colour code to paint
- brush  out  1  write enable to the pixel store
- newColor  out  3  write colour
- wx  out  8  write x; bit 7 is always 0
- wy  out  8  write y; bit 7 is always 0
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- State machine: IDLE, PAINT, CLEAR. The state register, latched command fields and the dx/dy counters are all flops.
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, brush=0, done=0, busy=0, cmd_ready=1 once reset is released;
  - wx=wy=0, newColor=0, all counters 0.
- Reset mid-command aborts immediately. No further writes are issued and the command is not resumed.
- cmd_ready = (state==IDLE). The command is accepted at a rising edge where cmd_valid and cmd_ready are both 1.
  - cmd_valid while busy is ignored. The command is not queued; the upstream must hold it until it is accepted.
- On acceptance of a paint command (cmd_clear=0):
  - latch x, y, color and r=min(cmd_size, MAX_RADIUS);
  - set dy=-r, dx=-r; next state PAINT.
- PAINT:
  - One footprint position per cycle, in raster order: dx runs -r..+r inside, dy runs -r..+r outside.
  - Position px=x+dx, py=y+dy, computed as 9-bit signed values.
  - brush=1 only if 0<=px<CANVAS and 0<=py<CANVAS; otherwise brush=0 for that cycle (clipped, but the cycle is still consumed).
  - PAINT always lasts exactly (2r+1)^2 cycles.
  - At the edge that leaves the final position (dx=dy=+r), state returns to IDLE.
- On acceptance of a clear command (cmd_clear=1):
  - next state CLEAR, x/y counters reset to 0.
  - Writes ERASE_COLOR to every pixel, x inner and y outer, brush=1 every cycle, for CANVAS*CANVAS cycles (16384 by default).
  - State returns to IDLE after pixel (CANVAS-1, CANVAS-1).
- Outputs are combinational from registered state and counters only; there is no combinational path from any cmd_* input to any output.
  - wx={1'b0, px[6:0]}, wy={1'b0, py[6:0]}, newColor=latched colour (ERASE_COLOR in CLEAR).
  - When brush=0, wx, wy and newColor are don't-care but must be stable (no X).
- The first write appears in the cycle immediately after the accepting edge.
- busy=1 in PAINT and CLEAR.
- done=1 for exactly one cycle, the first IDLE cycle after PAINT or CLEAR.
  - A new command may be accepted in that same cycle.
- Back-to-back commands: at most one idle cycle between two commands. There is never a gap larger than this if cmd_valid is held.
- cmd_size greater than MAX_RADIUS (only possible when MAX_RADIUS<3) saturates to MAX_RADIUS.

Test Plan:
- Reset: assert reset=0 mid-PAINT (r=3 at (64,64), after 5 writes) -> brush=0 and cmd_ready=1 the next cycle after release; no further writes; done stays 0.
- Single pixel: cmd x=10, y=20, size=0, color=3'b010 -> exactly 1 cycle with brush=1, wx=10, wy=20, newColor=3'b010; done pulses on the next cycle.
- Corner clip: x=0, y=0, size=1 -> 9 PAINT cycles; brush=1 only for (0,0), (1,0), (0,1), (1,1), in that order.
- Far-corner clip: x=127, y=127, size=3 -> 49 PAINT cycles, 16 writes covering (124..127)x(124..127); wx/wy bit 7 is never set.
- Clear: cmd_clear=1 -> 16384 consecutive writes of ERASE_COLOR, first at (0,0), last at (127,127); busy=1 throughout.
- Handshake: cmd_valid held high with two queued commands (size 1, then size 0) -> second command accepted on the done cycle; a cmd change during busy has no effect.

Source files
------------

// File: rtl/brush_painter.sv
// Brush painter: turns paint/clear commands into a stream of single-pixel
// writes for the pixel store, one write per clock, with off-canvas clipping.
module brush_painter #(
    parameter int         CANVAS      = 128,
    parameter int         MAX_RADIUS  = 3,
    parameter logic [2:0] ERASE_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_clear,
    input  logic [6:0] cmd_x,
    input  logic [6:0] cmd_y,
    input  logic [1:0] cmd_size,
    input  logic [2:0] cmd_color,
    output logic       brush,
    output logic [2:0] newColor,
    output logic [7:0] wx,
    output logic [7:0] wy,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PAINT = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam logic [1:0] MAX_R     = (MAX_RADIUS >= 3) ? 2'd3 : 2'(MAX_RADIUS);
    localparam logic [6:0] LAST_POS  = 7'(CANVAS - 1);
    localparam logic [7:0] CANVAS_8  = 8'(CANVAS);

    logic [1:0] state_q, state_d;
    logic [6:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] color_q, color_d;
    logic [1:0] r_q, r_d;
    logic [3:0] dx_q, dx_d;
    logic [3:0] dy_q, dy_d;
    logic       done_q, done_d;

    logic [1:0] r_sat;
    logic [3:0] r_pos;
    logic [3:0] r_neg;
    logic [3:0] cmd_r_neg;
    logic [8:0] px;
    logic [8:0] py;
    logic       px_in;
    logic       py_in;

    // dx/dy are 4-bit two's complement offsets in -3..+3.
    assign r_sat     = (cmd_size > MAX_R) ? MAX_R : cmd_size;
    assign r_pos     = {2'b00, r_q};
    assign r_neg     = 4'd0 - r_pos;
    assign cmd_r_neg = 4'd0 - {2'b00, r_sat};

    assign px = {2'b00, x_q} + {{5{dx_q[3]}}, dx_q};
    assign py = {2'b00, y_q} + {{5{dy_q[3]}}, dy_q};

    assign px_in = !px[8] && (px[7:0] < CANVAS_8);
    assign py_in = !py[8] && (py[7:0] < CANVAS_8);

    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        r_d     = r_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_clear) begin
                        // Clear reuses x/y as raster counters with zero offsets.
                        state_d = S_CLEAR;
                        x_d     = 7'd0;
                        y_d     = 7'd0;
                        dx_d    = 4'd0;
                        dy_d    = 4'd0;
                    end else begin
                        state_d = S_PAINT;
                        x_d     = cmd_x;
                        y_d     = cmd_y;
                        color_d = cmd_color;
                        r_d     = r_sat;
                        dx_d    = cmd_r_neg;
                        dy_d    = cmd_r_neg;
                    end
                end
            end

            S_PAINT: begin
                if (dx_q == r_pos) begin
                    dx_d = r_neg;
                    if (dy_q == r_pos) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dy_d = dy_q + 4'd1;
                    end
                end else begin
                    dx_d = dx_q + 4'd1;
                end
            end

            S_CLEAR: begin
                if (x_q == LAST_POS) begin
                    x_d = 7'd0;
                    if (y_q == LAST_POS) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        y_d = y_q + 7'd1;
                    end
                end else begin
                    x_d = x_q + 7'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= 7'd0;
            y_q     <= 7'd0;
            color_q <= 3'd0;
            r_q     <= 2'd0;
            dx_q    <= 4'd0;
            dy_q    <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            r_q     <= r_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            done_q  <= done_d;
        end
    end

    // Outputs depend only on registered state, never on cmd_* inputs.
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_PAINT) || (state_q == S_CLEAR);
    assign done      = done_q;
    assign brush     = (state_q == S_CLEAR) || ((state_q == S_PAINT) && px_in && py_in);
    assign newColor  = (state_q == S_CLEAR) ? ERASE_COLOR : color_q;
    assign wx        = {1'b0, px[6:0]};
    assign wy        = {1'b0, py[6:0]};

endmodule

// File: tb/tb_brush_painter.sv
// Directed testbench for brush_painter: reset abort, single pixel, corner
// clipping, full clear and command handshake timing.
module tb_brush_painter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_clear = 1'b0;
    logic [6:0] cmd_x = 7'd0;
    logic [6:0] cmd_y = 7'd0;
    logic [1:0] cmd_size = 2'd0;
    logic [2:0] cmd_color = 3'd0;
    logic       brush;
    logic [2:0] newColor;
    logic [7:0] wx;
    logic [7:0] wy;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    int wq_x[$];
    int wq_y[$];
    int wq_c[$];
    int n_cycles;
    bit bit7_seen;
    bit done_seen;

    brush_painter dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clear (cmd_clear),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_size  (cmd_size),
        .cmd_color (cmd_color),
        .brush     (brush),
        .newColor  (newColor),
        .wx        (wx),
        .wy        (wy),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and returns 1ns after the accepting edge.
    task automatic issue(input logic clr, input logic [6:0] x, input logic [6:0] y,
                         input logic [1:0] sz, input logic [2:0] col);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        cmd_clear = clr;
        cmd_x     = x;
        cmd_y     = y;
        cmd_size  = sz;
        cmd_color = col;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Records every write while busy; stops on the first idle cycle.
    task automatic collect(input int limit);
        wq_x.delete();
        wq_y.delete();
        wq_c.delete();
        n_cycles  = 0;
        bit7_seen = 1'b0;
        while (busy === 1'b1 && n_cycles < limit) begin
            if (brush === 1'b1) begin
                wq_x.push_back(int'(wx));
                wq_y.push_back(int'(wy));
                wq_c.push_back(int'(newColor));
            end
            if (wx[7] !== 1'b0 || wy[7] !== 1'b0) bit7_seen = 1'b1;
            n_cycles++;
            step();
        end
        done_seen = (done === 1'b1);
    endtask

    task automatic test_reset();
        int writes;
        int stray;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        total++; if (brush !== 1'b0) begin bad++; $display("FAIL rst_brush: got %b want 0", brush); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
        total++; if (wx !== 8'd0 || wy !== 8'd0 || newColor !== 3'd0) begin
            bad++; $display("FAIL rst_outputs: got wx=%0d wy=%0d c=%0d want 0 0 0", wx, wy, newColor);
        end

        issue(1'b0, 7'd64, 7'd64, 2'd3, 3'd6);
        writes = (brush === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (brush === 1'b1) writes++;
        end
        total++; if (writes != 5) begin bad++; $display("FAIL rst_pre_writes: got %0d want 5", writes); end
        #2 reset = 1'b0;
        #1;
        total++; if (brush !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_async: got brush=%b busy=%b want 0 0", brush, busy); end
        step();
        reset = 1'b1;
        step();
        total++; if (brush !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL rst_release: got brush=%b ready=%b done=%b want 0 1 0", brush, cmd_ready, done);
        end
        stray = 0;
        for (int i = 0; i < 60; i++) begin
            if (brush !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray++;
            step();
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rst_no_resume: got %0d active cycles want 0", stray); end
    endtask

    task automatic test_single();
        issue(1'b0, 7'd10, 7'd20, 2'd0, 3'b010);
        collect(100);
        total++; if (n_cycles != 1) begin bad++; $display("FAIL single_cycles: got %0d want 1", n_cycles); end
        total++; if (wq_x.size() != 1) begin bad++; $display("FAIL single_writes: got %0d want 1", wq_x.size()); end
        else begin
            total++; if (wq_x[0] != 10 || wq_y[0] != 20 || wq_c[0] != 2) begin
                bad++; $display("FAIL single_pixel: got (%0d,%0d) c=%0d want (10,20) c=2", wq_x[0], wq_y[0], wq_c[0]);
            end
        end
        total++; if (!done_seen) begin bad++; $display("FAIL single_done: got done=%b want 1", done); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_width: got done=%b want 0", done); end
    endtask

    task automatic test_corner();
        int ex[4] = '{0, 1, 0, 1};
        int ey[4] = '{0, 0, 1, 1};
        int errs = 0;
        issue(1'b0, 7'd0, 7'd0, 2'd1, 3'd5);
        collect(100);
        total++; if (n_cycles != 9) begin bad++; $display("FAIL corner_cycles: got %0d want 9", n_cycles); end
        total++; if (wq_x.size() != 4) begin bad++; $display("FAIL corner_writes: got %0d want 4", wq_x.size()); end
        for (int i = 0; i < wq_x.size() && i < 4; i++)
            if (wq_x[i] != ex[i] || wq_y[i] != ey[i] || wq_c[i] != 5) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL corner_order: got %0d wrong writes want 0", errs); end
        total++; if (!done_seen) begin bad++; $display("FAIL corner_done: got done=0 want 1"); end
    endtask

    task automatic test_far_corner();
        int errs = 0;
        issue(1'b0, 7'd127, 7'd127, 2'd3, 3'd7);
        collect(200);
        total++; if (n_cycles != 49) begin bad++; $display("FAIL far_cycles: got %0d want 49", n_cycles); end
        total++; if (wq_x.size() != 16) begin bad++; $display("FAIL far_writes: got %0d want 16", wq_x.size()); end
        for (int i = 0; i < wq_x.size() && i < 16; i++)
            if (wq_x[i] != 124 + i % 4 || wq_y[i] != 124 + i / 4 || wq_c[i] != 7) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL far_pixels: got %0d wrong writes want 0", errs); end
        total++; if (bit7_seen) begin bad++; $display("FAIL far_bit7: got bit7 set want clear"); end
    endtask

    task automatic test_size2();
        int errs = 0;
        issue(1'b0, 7'd5, 7'd5, 2'd2, 3'd3);
        collect(100);
        total++; if (n_cycles != 25 || wq_x.size() != 25) begin
            bad++; $display("FAIL size2_count: got cycles=%0d writes=%0d want 25 25", n_cycles, wq_x.size());
        end
        for (int i = 0; i < wq_x.size() && i < 25; i++)
            if (wq_x[i] != 3 + i % 5 || wq_y[i] != 3 + i / 5) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL size2_raster: got %0d wrong writes want 0", errs); end
    endtask

    task automatic test_clear();
        int errs = 0;
        issue(1'b1, 7'd77, 7'd33, 2'd3, 3'd6);
        collect(20000);
        total++; if (n_cycles != 16384) begin bad++; $display("FAIL clear_cycles: got %0d want 16384", n_cycles); end
        total++; if (wq_x.size() != 16384) begin bad++; $display("FAIL clear_writes: got %0d want 16384", wq_x.size()); end
        for (int i = 0; i < wq_x.size(); i++)
            if (wq_x[i] != i % 128 || wq_y[i] != i / 128 || wq_c[i] != 0) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL clear_pixels: got %0d wrong writes want 0", errs); end
        if (wq_x.size() > 0) begin
            total++; if (wq_x[0] != 0 || wq_y[0] != 0 || wq_x[wq_x.size()-1] != 127 || wq_y[wq_y.size()-1] != 127) begin
                bad++; $display("FAIL clear_ends: got first (%0d,%0d) last (%0d,%0d) want (0,0) (127,127)",
                                wq_x[0], wq_y[0], wq_x[wq_x.size()-1], wq_y[wq_y.size()-1]);
            end
        end
        total++; if (!done_seen) begin bad++; $display("FAIL clear_done: got done=0 want 1"); end
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        cmd_clear = 1'b0;
        cmd_x     = 7'd50;
        cmd_y     = 7'd50;
        cmd_size  = 2'd1;
        cmd_color = 3'd1;
        cmd_valid = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            if (brush !== 1'b1 || wx !== 8'(49 + i % 3) || wy !== 8'(49 + i / 3) || newColor !== 3'd1) errs++;
            if (i == 1) begin
                cmd_clear = 1'b1;
                cmd_x     = 7'd0;
            end
            if (i == 3) begin
                cmd_clear = 1'b0;
                cmd_x     = 7'd30;
                cmd_y     = 7'd40;
                cmd_size  = 2'd0;
                cmd_color = 3'd4;
            end
            step();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_first: got %0d wrong cycles want 0", errs); end
        total++; if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_done_cycle: got done=%b ready=%b busy=%b want 1 1 0", done, cmd_ready, busy);
        end
        step();
        total++; if (busy !== 1'b1 || brush !== 1'b1 || wx !== 8'd30 || wy !== 8'd40 || newColor !== 3'd4) begin
            bad++; $display("FAIL b2b_second: got busy=%b brush=%b (%0d,%0d) c=%0d want 1 1 (30,40) c=4",
                            busy, brush, wx, wy, newColor);
        end
        cmd_valid = 1'b0;
        step();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_second_done: got done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_far_corner();
        test_size2();
        test_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
